// File: rtl/ex_div_unit.sv
// Iterative RV32M divide/remainder unit for the EX stage: restoring radix-2, one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN short-circuits divide-by-zero and signed overflow straight to DONE.

package ex_defs_pkg;
  localparam int unsigned DATA_WIDTH = 32;
endpackage

module ex_div_unit
  import ex_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_accept;
  logic                  w_step;
  logic                  w_finish;
  logic                  w_fast_accept;

  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_dvd;
  logic [DATA_WIDTH-1:0] r_dsr;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [DATA_WIDTH-1:0] r_rem;
  logic                  r_q_neg;
  logic                  r_r_neg;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic                  w_in_div0;
  logic                  w_special;
  logic [DATA_WIDTH-1:0] w_fast_res;

  logic [DATA_WIDTH:0]   w_rem_sh;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_rem_nxt;
  logic [DATA_WIDTH-1:0] w_quot_nxt;
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;
  logic [DATA_WIDTH-1:0] w_result_nxt;

  // Operand conditioning at acceptance: DIV/REM (op_i[0]==0) are signed
  assign w_signed  = ~op_i[0];
  assign w_a_neg   = w_signed & rs1_i[DATA_WIDTH-1];
  assign w_b_neg   = w_signed & rs2_i[DATA_WIDTH-1];
  assign w_a_mag   = w_a_neg ? -rs1_i : rs1_i;
  assign w_b_mag   = w_b_neg ? -rs2_i : rs2_i;
  assign w_in_div0 = (rs2_i == '0);

`ifdef DIV_FAST_SPECIAL_EN
  logic w_in_ovf;
  assign w_in_ovf  = w_signed & (rs1_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (&rs2_i);
  assign w_special = w_in_div0 | w_in_ovf;
  assign w_fast_res = op_i[1] ? (w_in_div0 ? rs1_i : '0)
                              : (w_in_div0 ? '1 : {1'b1, {(DATA_WIDTH-1){1'b0}}});
`else
  assign w_special  = 1'b0;
  assign w_fast_res = '0;
`endif

  // One restoring shift-subtract step
  assign w_rem_sh   = {r_rem, r_dvd[DATA_WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_dsr};
  assign w_qbit     = ~w_diff[DATA_WIDTH];
  assign w_rem_nxt  = w_qbit ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
  assign w_quot_nxt = {r_quot[DATA_WIDTH-2:0], w_qbit};

  // Sign fixup; a zero divisor never negates the all-ones quotient
  assign w_q_fix      = (r_q_neg & ~r_op[0]) ? -w_quot_nxt : w_quot_nxt;
  assign w_r_fix      = (r_r_neg & ~r_op[0]) ? -w_rem_nxt  : w_rem_nxt;
  assign w_result_nxt = r_op[1] ? w_r_fix : w_q_fix;

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    w_finish      = 1'b0;
    w_fast_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          w_accept = 1'b1;
          if (w_special) begin
            w_fast_accept = 1'b1;
            w_state_nxt   = S_DONE;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_BUSY);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= op_i;
        r_dvd   <= w_a_mag;
        r_dsr   <= w_b_mag;
        r_quot  <= '0;
        r_rem   <= '0;
        r_q_neg <= (rs1_i[DATA_WIDTH-1] ^ rs2_i[DATA_WIDTH-1]) & ~w_in_div0;
        r_r_neg <= rs1_i[DATA_WIDTH-1];
        r_cnt   <= CNT_W'(DATA_WIDTH);
      end
      if (w_step) begin
        r_dvd  <= r_dvd << 1;
        r_quot <= w_quot_nxt;
        r_rem  <= w_rem_nxt;
        r_cnt  <= r_cnt - CNT_W'(1);
      end
      if (w_finish) begin
        r_result <= w_result_nxt;
      end
      if (w_fast_accept) begin
        r_result <= w_fast_res;
      end
    end
  end

  // Stall holds the front end from acceptance until the DONE edge
  assign stall_o  = w_accept | (r_state == S_BUSY);
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: directed RV32M cases plus random traffic against an arithmetic reference model.
module tb_ex_div_unit;
  import ex_defs_pkg::*;

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] rs1_i;
  logic [W-1:0] rs2_i;
  logic         flush_i;
  logic         stall_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ex_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ovf(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Architectural RV32M result from plain integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (is_ovf(op, a, b)) return 32'h8000_0000;
               else return 32'(sa / sb);
      OP_DIVU: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      OP_REM:  if (b == 0) return a;
               else if (is_ovf(op, a, b)) return 32'h0;
               else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Cycles from acceptance edge until done_o
  function automatic int lat_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 0 || is_ovf(op, a, b)) return 1;
`endif
    return W + 1;
  endfunction

  // Reference model: an accepted op lives m_lat cycles; result appears on the last
  bit           m_active = 0;
  int           m_cnt = 0;
  int           m_lat = 0;
  logic [W-1:0] m_exp = '0;
  logic [W-1:0] m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_cnt    = 0;
      m_result = '0;
    end else if (m_active) begin
      if (flush_i || m_cnt == m_lat) m_active = 0;
      else begin
        m_cnt++;
        if (m_cnt == m_lat) m_result = m_exp;
      end
    end else if (start_i && !flush_i) begin
      m_active = 1;
      m_cnt    = 1;
      m_lat    = lat_of(op_i, rs1_i, rs2_i);
      m_exp    = ref_div(op_i, rs1_i, rs2_i);
      if (m_lat == 1) m_result = m_exp;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_busy;
      logic e_done;
      logic e_stall;
      e_busy  = m_active && (m_cnt < m_lat);
      e_done  = m_active && (m_cnt == m_lat);
      e_stall = (!m_active && start_i && !flush_i) || e_busy;
      check("cyc_busy", 32'(busy_o), 32'(e_busy));
      check("cyc_done", 32'(done_o), 32'(e_done));
      check("cyc_stall", 32'(stall_o), 32'(e_stall));
      check("cyc_result", result_o, m_result);
    end
  end

  // Issue one op from IDLE (called at posedge+1); operands scrambled once accepted
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    check({name, "_model"}, ref_div(op, a, b), exp);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    for (n = 1; n <= int'(W) + 8; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start_i = 1'b0;
        op_i    = 2'($urandom);
        rs1_i   = $urandom;
        rs2_i   = $urandom;
      end
      if (done_o) break;
    end
    check({name, "_lat"}, 32'(n), 32'(lat_of(op, a, b)));
    check({name, "_res"}, result_o, exp);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int  dones;
    bit  seen;
    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_result", result_o, 32'h0);
    chk_en = 1;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_op("div_m100_7", OP_DIV, -32'sd100, 32'd7, 32'hFFFF_FFF2);
    run_op("rem_m100_7", OP_REM, -32'sd100, 32'd7, 32'hFFFF_FFFE);
    run_op("rem_100_m7", OP_REM, 32'd100, -32'sd7, 32'd2);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5);
    run_op("rem_m5_0", OP_REM, -32'sd5, 32'd0, 32'hFFFF_FFFB);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Flush in BUSY cycle 10
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_stall", 32'(stall_o), 32'h0);
    check("flush_busy", 32'(busy_o), 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) seen = 1;
    end
    check("flush_no_done", 32'(seen), 32'h0);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);

    // Reset in BUSY cycle 5
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd777; rs2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall_o), 32'h0);
    check("arst_busy", 32'(busy_o), 32'h0);
    check("arst_done", 32'(done_o), 32'h0);
    check("arst_result", result_o, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op("b2b_1", OP_DIVU, 32'd12345, 32'd17, 32'd726);
    run_op("b2b_2", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
    run_op("b2b_3", OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5);

    // Random traffic, including mid-op operand churn, stray starts and flushes
    dones = 0;
    for (int i = 0; i < 3000; i++) begin
      start_i = ($urandom % 4) == 0;
      flush_i = ($urandom % 48) == 0;
      op_i    = 2'($urandom);
      rs1_i   = pick();
      rs2_i   = pick();
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    check("rand_dones_seen", 32'(dones > 10), 32'h1);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
